// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator: captures A/B on start, resolves one bit per clock,
// and reports registered lt/gt/eq with a one-cycle done pulse.
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic                         lt,
  output logic                         gt,
  output logic                         eq,
  output logic [$clog2(WIDTH+1)-1:0]   cycles
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d, cycles_q, cycles_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
  logic            bit_l, bit_g, bit_e;

  // Same L/G/E relation as the 1-bit comparator, applied to the current MSBs.
  assign bit_l = ~sa_q[WIDTH-1] &  sb_q[WIDTH-1];
  assign bit_g =  sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
  assign bit_e = ~(sa_q[WIDTH-1] ^ sb_q[WIDTH-1]);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    busy_d   = busy_q;
    done_d   = done_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          cnt_d    = CW'(WIDTH);
          cycles_d = '0;
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          eq_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        cycles_d = cycles_q + ONE;
        if (EARLY_EXIT && !bit_e) begin
          lt_d    = bit_l;
          gt_d    = bit_g;
          eq_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << 1;
          sb_d  = sb_q << 1;
          cnt_d = cnt_q - ONE;
          // First difference wins; later bits never overwrite it.
          if (!lt_q && !gt_q) begin
            lt_d = bit_l;
            gt_d = bit_g;
          end
          if (cnt_q == ONE) begin
            eq_d    = ~(lt_d | gt_d);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign lt     = lt_q;
  assign gt     = gt_q;
  assign eq     = eq_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench: WIDTH=1 instance plus two WIDTH=8 instances (early-exit and constant-latency)
// driven with identical operands; expected values are hand-computed per vector.
module tb_serial_mag_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, a1, b1, start8;
  logic [7:0] a8, b8;
  logic       busy1, done1, lt1, gt1, eq1;
  logic [0:0] cycles1;
  logic       busy_e, done_e, lt_e, gt_e, eq_e;
  logic [3:0] cycles_e;
  logic       busy_f, done_f, lt_f, gt_f, eq_f;
  logic [3:0] cycles_f;

  int n_checks = 0;
  int n_errors = 0;

  serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .lt(lt1), .gt(gt1), .eq(eq1), .cycles(cycles1)
  );

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy_e), .done(done_e), .lt(lt_e), .gt(gt_e), .eq(eq_e), .cycles(cycles_e)
  );

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy_f), .done(done_f), .lt(lt_f), .gt(gt_f), .eq(eq_f), .cycles(cycles_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // exp = {lt,gt,eq}; ej = edge offset of the early-exit result after the accepting edge.
  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input int ej,
                      input logic [2:0] exp, input bit hold);
    a8 = va; b8 = vb; start8 = 1'b1;
    @(negedge clk);
    check("busy_start_e", 32'(busy_e), 32'd1);
    check("busy_start_f", 32'(busy_f), 32'd1);
    if (hold) a8 = 8'hFF;
    else start8 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      check("done_busy_e", 32'({done_e, busy_e}), 32'({n == ej, n < ej}));
      check("done_busy_f", 32'({done_f, busy_f}), 32'({n == 8, n < 8}));
      if (n == 1) check("cycles_step1_e", 32'(cycles_e), 32'd1);
      if (n == 1 && ej > 1) check("cleared_e", 32'({lt_e, gt_e, eq_e}), 32'd0);
      if (n == ej || n == 10) begin
        check("result_e", 32'({lt_e, gt_e, eq_e}), 32'(exp));
        check("cycles_e", 32'(cycles_e), 32'(ej));
      end
      if (n == 8 || n == 10) begin
        check("result_f", 32'({lt_f, gt_f, eq_f}), 32'(exp));
        check("cycles_f", 32'(cycles_f), 32'd8);
      end
      if (hold && n == 8) start8 = 1'b0;
    end
    $display("run a=%02h b=%02h early: lt=%0d gt=%0d eq=%0d cyc=%0d | full: lt=%0d gt=%0d eq=%0d cyc=%0d",
             va, vb, lt_e, gt_e, eq_e, cycles_e, lt_f, gt_f, eq_f, cycles_f);
  endtask

  initial begin
    logic [2:0] w1_exp;
    rst = 1'b1; start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset_w1", 32'({busy1, done1, lt1, gt1, eq1, cycles1}), 32'd0);
    check("reset_e", 32'({busy_e, done_e, lt_e, gt_e, eq_e, cycles_e}), 32'd0);
    check("reset_f", 32'({busy_f, done_f, lt_f, gt_f, eq_f, cycles_f}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=1 truth table: 00 eq, 01 lt, 10 gt, 11 eq
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0]; start1 = 1'b1;
      w1_exp = (i == 1) ? 3'b100 : (i == 2) ? 3'b010 : 3'b001;
      @(negedge clk);
      check("w1_busy", 32'(busy1), 32'd1);
      start1 = 1'b0;
      @(negedge clk);
      check("w1_done", 32'(done1), 32'd1);
      check("w1_result", 32'({lt1, gt1, eq1}), 32'(w1_exp));
      check("w1_cycles", 32'(cycles1), 32'd1);
      @(negedge clk);
      check("w1_done_off", 32'({done1, busy1}), 32'd0);
      $display("w1 a=%0d b=%0d lt=%0d gt=%0d eq=%0d", a1, b1, lt1, gt1, eq1);
    end

    run8(8'h5A, 8'h5A, 8, 3'b001, 1'b0);
    run8(8'h80, 8'h7F, 1, 3'b010, 1'b0);
    run8(8'h12, 8'h13, 8, 3'b100, 1'b1);
    run8(8'h0F, 8'h10, 4, 3'b100, 1'b0);
    run8(8'hFF, 8'h00, 1, 3'b010, 1'b0);

    // Back-to-back: start held high through DONE, accepted again once IDLE
    a8 = 8'h40; b8 = 8'h20; start8 = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 2) begin
        check("b2b_done", 32'(done_e), 32'd1);
        check("b2b_result", 32'({lt_e, gt_e, eq_e}), 32'b010);
        check("b2b_cycles", 32'(cycles_e), 32'd2);
      end
      if (n == 3) check("b2b_ignored_in_done", 32'({done_e, busy_e}), 32'd0);
      if (n == 4) begin
        check("b2b_reaccept_busy", 32'(busy_e), 32'd1);
        check("b2b_reaccept_clear", 32'({lt_e, gt_e, eq_e, cycles_e}), 32'd0);
      end
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b_second_result", 32'({lt_e, gt_e, eq_e, cycles_e}), 32'({3'b010, 4'd2}));
    $display("b2b a=40 b=20 lt=%0d gt=%0d eq=%0d cyc=%0d", lt_e, gt_e, eq_e, cycles_e);

    // Reset in the third COMPARE cycle, with start held to confirm rst priority
    a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start8 = 1'b1;
    @(negedge clk);
    check("midrst_e", 32'({busy_e, done_e, lt_e, gt_e, eq_e, cycles_e}), 32'd0);
    check("midrst_f", 32'({busy_f, done_f, lt_f, gt_f, eq_f, cycles_f}), 32'd0);
    rst = 1'b0; start8 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("midrst_no_done", 32'({done_e, done_f, busy_e, busy_f}), 32'd0);
    end
    $display("midrst busy_e=%0d busy_f=%0d done_e=%0d done_f=%0d", busy_e, busy_f, done_e, done_f);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
